uart_rx_byte: RTL and testbench

UART receive front end: oversamples the asynchronous `rx_serial` line and delivers each correctly framed 8N1 byte as a one-cycle `rx_valid` pulse with the data on `rx_byte`. It sits directly upstream of `uart_collector`, which packs the bytes into 32-bit instruction words. Malformed frames are reported on `frame_error` and are never forwarded.

---
 rtl/uart_rx_byte.sv | 175 +++++++++++++++++
 tb/tb_uart_rx_byte.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 UART receiver. It oversamples the asynchronous serial line,
// samples each bit at its middle relative to the detected start edge, and
// delivers correctly framed bytes as a one-cycle rx_valid pulse. A stop bit
// sampled low is reported on frame_error, and that byte is not delivered.
// A line held low (break) is swallowed until it returns high, so it is not
// decoded as a stream of 0x00 bytes.
`timescale 1ns/1ps

module uart_rx_byte #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD_RATE   = 115200
) (
  input  logic       clk,
  input  logic       rst,          // asynchronous, active low
  input  logic       rx_serial,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_error,
  output logic       rx_busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);

  // With fewer than four clocks per bit there is no usable mid-bit sample point.
  generate
    if (CLKS_PER_BIT < 4) begin : g_bad_ratio
      $fatal(1, "uart_rx_byte: CLK_FREQ_HZ / BAUD_RATE must be at least 4");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  logic [1:0]       sync_reg;
  logic             rx_s;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg,   cnt_next;
  logic [2:0]       idx_reg,   idx_next;
  logic [7:0]       sh_reg,    sh_next;
  logic [7:0]       byte_reg,  byte_next;
  logic             valid_reg, valid_next;
  logic             ferr_reg,  ferr_next;
  logic             busy_reg;

  // Two-flop synchronizer; flops reset to the idle (high) line level so that
  // reset release never looks like a start edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_reg <= 2'b11;
    end else begin
      sync_reg <= {sync_reg[0], rx_serial};
    end
  end

  assign rx_s = sync_reg[1];

  // FSM and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      idx_reg   <= 3'd0;
      sh_reg    <= 8'h00;
      byte_reg  <= 8'h00;
      valid_reg <= 1'b0;
      ferr_reg  <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      sh_reg    <= sh_next;
      byte_reg  <= byte_next;
      valid_reg <= valid_next;
      ferr_reg  <= ferr_next;
      busy_reg  <= (state_reg != IDLE);
    end
  end

  // Next-state and datapath logic: sample at half a bit into the start bit,
  // then once per full bit period for the eight data bits and the stop bit.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    sh_next    = sh_reg;
    byte_next  = byte_reg;
    valid_next = 1'b0;
    ferr_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (!rx_s) begin
          state_next = START;
          cnt_next   = '0;
        end
      end

      START: begin
        if (cnt_reg == CNT_HALF_LAST) begin
          cnt_next = '0;
          if (!rx_s) begin
            state_next = DATA;
            idx_next   = 3'd0;
          end else begin
            // Line went back high before mid-start: treat as a glitch.
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end

      DATA: begin
        if (cnt_reg == CNT_BIT_LAST) begin
          sh_next  = {rx_s, sh_reg[7:1]};
          cnt_next = '0;
          if (idx_reg == 3'd7) begin
            state_next = STOP;
          end else begin
            idx_next = idx_reg + 3'd1;
          end
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end

      STOP: begin
        if (cnt_reg == CNT_BIT_LAST) begin
          cnt_next = '0;
          if (rx_s) begin
            // Leaving at mid-stop lets a start bit right after the stop bit be seen.
            byte_next  = sh_reg;
            valid_next = 1'b1;
            state_next = IDLE;
          end else begin
            ferr_next  = 1'b1;
            state_next = BREAK;
          end
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end

      BREAK: begin
        if (rx_s) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign rx_byte     = byte_reg;
  assign rx_valid    = valid_reg;
  assign frame_error = ferr_reg;
  assign rx_busy     = busy_reg;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte. A scoreboard queue holds the bytes each
// transmitted frame should produce; a monitor pops and compares them on rx_valid.
`timescale 1ns/1ps

module tb_uart_rx_byte;

  localparam int CLK_HZ  = 100_000_000;
  localparam int BAUD    = 400_000;
  localparam int CPB     = CLK_HZ / BAUD;        // 250 clocks per bit
  localparam int HALF    = CPB / 2;              // 125
  localparam int LAT     = 2 + HALF + 9 * CPB + 1;
  localparam int STRETCH = 100;                  // 1000 ns at 10 ns clock

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_serial = 1'b1;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       frame_error;
  logic       rx_busy;

  always #5 clk = ~clk;

  uart_rx_byte #(
    .CLK_FREQ_HZ(CLK_HZ),
    .BAUD_RATE  (BAUD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_serial  (rx_serial),
    .rx_byte    (rx_byte),
    .rx_valid   (rx_valid),
    .frame_error(frame_error),
    .rx_busy    (rx_busy)
  );

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [7:0] sb[$];
  int         valid_cnt = 0;
  int         ferr_cnt = 0;
  int         last_valid_cyc = 0;
  int         prev_valid_cyc = 0;
  int         frame_start_cyc = 0;
  logic       busy_seen = 1'b0;
  logic [7:0] prev_byte = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_range(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Drive one 8N1 frame; must be called at a falling edge and returns at one.
  task automatic send_byte(input logic [7:0] b, input int stretch);
    sb.push_back(b);
    rx_serial       = 1'b0;
    frame_start_cyc = cyc + 1;
    repeat (CPB + stretch) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_serial = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx_serial = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  // Monitor: one sample 1 ns after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (rx_valid === 1'b1) begin
        valid_cnt++;
        prev_valid_cyc = last_valid_cyc;
        last_valid_cyc = cyc;
        if (sb.size() == 0) begin
          chk("unexpected_valid", 32'(rx_byte), 32'hFFFF_FFFF);
        end else begin
          logic [7:0] exp_b;
          exp_b = sb.pop_front();
          chk("rx_byte_vs_scoreboard", 32'(rx_byte), 32'(exp_b));
          $display("cycle %0d: rx_valid byte 0x%02h expected 0x%02h", cyc, rx_byte, exp_b);
        end
      end
      if (rx_valid === 1'b1 || frame_error === 1'b1) begin
        chk("valid_and_ferr_exclusive", 32'(rx_valid & frame_error), 32'h0);
      end
      if (frame_error === 1'b1) begin
        ferr_cnt++;
        $display("cycle %0d: frame_error pulse", cyc);
      end
      if (rst === 1'b1 && rx_byte !== prev_byte) begin
        chk("rx_byte_changes_only_with_valid", 32'(rx_valid), 32'h1);
      end
      prev_byte = rx_byte;
      if (rx_busy === 1'b1) busy_seen = 1'b1;
    end
  end

  // Watchdog: the directed sequence is bounded, so this only fires on a hang.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout at cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int v0;
    int f0;

    // Reset state while reset is held.
    repeat (5) @(negedge clk);
    chk("reset_rx_byte", 32'(rx_byte), 32'h00);
    chk("reset_rx_valid", 32'(rx_valid), 32'h0);
    chk("reset_frame_error", 32'(frame_error), 32'h0);
    chk("reset_rx_busy", 32'(rx_busy), 32'h0);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_after_reset_busy", 32'(rx_busy), 32'h0);

    // Basic byte with latency.
    v0 = valid_cnt; f0 = ferr_cnt;
    send_byte(8'h13, 0);
    chk("basic_valid_count", 32'(valid_cnt - v0), 32'd1);
    chk_range("basic_latency", last_valid_cyc - frame_start_cyc, LAT - 1, LAT + 1);
    chk("basic_rx_byte", 32'(rx_byte), 32'h13);
    chk("basic_no_ferr", 32'(ferr_cnt - f0), 32'd0);
    chk("basic_busy_low", 32'(rx_busy), 32'h0);

    // Back-to-back frames, no idle gap.
    v0 = valid_cnt;
    send_byte(8'hAA, 0);
    send_byte(8'h55, 0);
    chk("b2b_valid_count", 32'(valid_cnt - v0), 32'd2);
    chk_range("b2b_spacing", last_valid_cyc - prev_valid_cyc, 10 * CPB - 1, 10 * CPB + 1);
    chk("b2b_last_byte", 32'(rx_byte), 32'h55);

    // Start glitch of 200 ns.
    v0 = valid_cnt; f0 = ferr_cnt;
    busy_seen = 1'b0;
    rx_serial = 1'b0;
    repeat (20) @(negedge clk);
    rx_serial = 1'b1;
    repeat (HALF + 10) @(negedge clk);
    chk("glitch_busy_pulsed", 32'(busy_seen), 32'h1);
    chk("glitch_back_to_idle", 32'(rx_busy), 32'h0);
    chk("glitch_no_valid", 32'(valid_cnt - v0), 32'd0);
    chk("glitch_no_ferr", 32'(ferr_cnt - f0), 32'd0);
    send_byte(8'hCC, 0);
    chk("after_glitch_byte", 32'(rx_byte), 32'hCC);

    // Break: line low for 20 bit periods.
    v0 = valid_cnt; f0 = ferr_cnt;
    rx_serial = 1'b0;
    repeat (20 * CPB) @(negedge clk);
    rx_serial = 1'b1;
    repeat (CPB) @(negedge clk);
    chk("break_one_ferr", 32'(ferr_cnt - f0), 32'd1);
    chk("break_no_valid", 32'(valid_cnt - v0), 32'd0);
    chk("break_byte_held", 32'(rx_byte), 32'hCC);
    chk("break_busy_low", 32'(rx_busy), 32'h0);
    send_byte(8'hF0, 0);
    chk("after_break_byte", 32'(rx_byte), 32'hF0);

    // Reset in the middle of data bit 4 of 0xFF.
    rx_serial = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx_serial = 1'b1;
      repeat (CPB) @(negedge clk);
    end
    repeat (CPB / 2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("midreset_rx_byte", 32'(rx_byte), 32'h00);
    chk("midreset_rx_valid", 32'(rx_valid), 32'h0);
    chk("midreset_frame_error", 32'(frame_error), 32'h0);
    chk("midreset_rx_busy", 32'(rx_busy), 32'h0);
    rst = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    v0 = valid_cnt;
    send_byte(8'h0F, 0);
    chk("midreset_valid_count", 32'(valid_cnt - v0), 32'd1);
    chk("midreset_next_byte", 32'(rx_byte), 32'h0F);

    // Start bit stretched by 1000 ns.
    v0 = valid_cnt; f0 = ferr_cnt;
    send_byte(8'h00, STRETCH);
    send_byte(8'hFF, STRETCH);
    send_byte(8'hCC, STRETCH);
    send_byte(8'hF0, STRETCH);
    chk("stretch_valid_count", 32'(valid_cnt - v0), 32'd4);
    chk("stretch_no_ferr", 32'(ferr_cnt - f0), 32'd0);
    chk("stretch_last_byte", 32'(rx_byte), 32'hF0);

    repeat (10) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
